// File: rtl/scsi_dma_pkg.sv
// Shared types and constants for the SCSI DMA sequencer.
// Holds the one-hot state encoding, the registered-output bundle,
// the byte-lane width helper and the legal strobe-width range.
package scsi_dma_pkg;

  // Strobe hold range; the inline strobe counter is sized for the maximum
  localparam int STROBE_CYC_MIN = 1;
  localparam int STROBE_CYC_MAX = 15;
  localparam int STB_CNT_W      = 4;

  // One-hot sequencer states
  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_CPU_STB = 6'b000010,
    S_CPU_END = 6'b000100,
    S_DMA_STB = 6'b001000,
    S_DMA_END = 6'b010000,
    S_FLUSH   = 6'b100000
  } seq_state_e;

  // Every strobe, steering line and pulse leaves the block through this register
  typedef struct packed {
    logic scsi_cs;
    logic re;
    logic we;
    logic dack;
    logic set_dsack;
    logic cpu2s;
    logic s2cpu;
    logic f2s;
    logic s2f;
    logic rdfifo;
    logic rififo;
    logic incbo;
    logic incni;
    logic incno;
  } seq_out_t;

  // Width of the byte-lane pointer for a power-of-two word size
  function automatic int bo_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

  // Keep an out-of-range strobe width inside what the counter can represent
  function automatic int clamp_strobe(input int cyc);
    if (cyc < STROBE_CYC_MIN) return STROBE_CYC_MIN;
    if (cyc > STROBE_CYC_MAX) return STROBE_CYC_MAX;
    return cyc;
  endfunction

endpackage

// File: rtl/scsi_dma_tc.sv
// Terminal byte counter for the SCSI DMA sequencer.
// Only instantiated when SCSI_DMA_SEQ_TC_EN is defined. A load of zero
// reports done at once; otherwise done rises on the decrement that reaches 0.
module scsi_dma_tc
  import scsi_dma_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // Load, count down once per completed byte, flag exhaustion
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_val;
      r_done <= (i_val == '0);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CNT_W'(1));
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/scsi_dma_seq.sv
// SCSI bus sequencer: arbitrates CPU register accesses against DMA byte
// transfers, generates programmable-width strobes, owns the FIFO byte
// pointer and flushes partial S2F words when DMA stops.
// Optional terminal count: define SCSI_DMA_SEQ_TC_EN.
// All outputs come from one register fed by the state decode, so every
// strobe and pulse appears one cycle after the state that produces it.
module scsi_dma_seq
  import scsi_dma_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int STROBE_CYC     = 2,
  parameter int CNT_W          = 24
) (
  input  logic                                CLK,
  input  logic                                nRESET,
  input  logic                                CCPUREQ,
  input  logic                                RW,
  input  logic                                CDREQ_,
  input  logic                                DMAENA,
  input  logic                                DMADIR,
  input  logic                                FIFOEMPTY,
  input  logic                                FIFOFULL,
  input  logic                                CLR_BO,
  input  logic                                TC_LOAD,
  input  logic [CNT_W-1:0]                    TC_VAL,
  output logic                                SCSI_CS,
  output logic                                RE,
  output logic                                WE,
  output logic                                DACK,
  output logic                                SET_DSACK,
  output logic                                CPU2S,
  output logic                                S2CPU,
  output logic                                F2S,
  output logic                                S2F,
  output logic                                RDFIFO,
  output logic                                RIFIFO,
  output logic                                INCBO,
  output logic                                INCNI,
  output logic                                INCNO,
  output logic [bo_width(BYTES_PER_WORD)-1:0] BO,
  output logic                                TC_DONE
);

  localparam int                  BO_W     = bo_width(BYTES_PER_WORD);
  localparam logic [BO_W-1:0]     BO_LAST  = BO_W'(BYTES_PER_WORD - 1);
  localparam logic [STB_CNT_W-1:0] STB_LAST = STB_CNT_W'(clamp_strobe(STROBE_CYC) - 1);

  seq_state_e           r_state, w_next;
  seq_out_t             r_out, w_out;
  logic [STB_CNT_W-1:0] r_stb_cnt;
  logic                 r_end_seen;
  logic [BO_W-1:0]      r_bo;
  logic                 w_stb_last;
  logic                 w_ready;
  logic                 w_dma_req;
  logic                 w_flush_pend;
  logic                 w_tc_done;

  assign w_stb_last   = (r_stb_cnt == STB_LAST);
  assign w_ready      = DMADIR ? ((r_bo != '0) || !FIFOEMPTY) : !FIFOFULL;
  assign w_dma_req    = DMAENA && !CDREQ_ && !w_tc_done && w_ready;
  assign w_flush_pend = !DMAENA && !DMADIR && (r_bo != '0);

`ifdef SCSI_DMA_SEQ_TC_EN
  scsi_dma_tc #(.CNT_W(CNT_W)) u_tc (
    .CLK    (CLK),
    .nRESET (nRESET),
    .i_load (TC_LOAD && (r_state == S_IDLE)),
    .i_val  (TC_VAL),
    .i_dec  (r_state == S_DMA_END),
    .o_done (w_tc_done)
  );
`else
  logic w_tc_unused;
  assign w_tc_unused = ^{TC_LOAD, TC_VAL};
  assign w_tc_done   = 1'b0;
`endif

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and output decode from the current state
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    w_out  = '0;
    case (r_state)
      S_IDLE: begin
        if (CCPUREQ)           w_next = S_CPU_STB;
        else if (w_dma_req)    w_next = S_DMA_STB;
        else if (w_flush_pend) w_next = S_FLUSH;
      end
      S_CPU_STB: begin
        w_out.scsi_cs = 1'b1;
        w_out.re      = RW;
        w_out.we      = !RW;
        w_out.cpu2s   = !RW;
        w_out.s2cpu   = RW;
        if (w_stb_last) w_next = S_CPU_END;
      end
      S_CPU_END: begin
        // Acknowledge once; then hold off re-arbitration until the CPU lets go
        w_out.set_dsack = !r_end_seen;
        if (!CCPUREQ) w_next = S_IDLE;
      end
      S_DMA_STB: begin
        w_out.dack   = 1'b1;
        w_out.we     = DMADIR;
        w_out.re     = !DMADIR;
        w_out.f2s    = DMADIR;
        w_out.s2f    = !DMADIR;
        // A fresh F2S word is fetched as its first byte goes out
        w_out.rdfifo = DMADIR && (r_bo == '0) && (r_stb_cnt == '0);
        if (w_stb_last) w_next = S_DMA_END;
      end
      S_DMA_END: begin
        w_out.incbo = 1'b1;
        if (r_bo == BO_LAST) begin
          w_out.incno  = DMADIR;
          w_out.rififo = !DMADIR;
          w_out.incni  = !DMADIR;
        end
        w_next = S_IDLE;
      end
      S_FLUSH: begin
        if (!FIFOFULL) begin
          w_out.rififo = 1'b1;
          w_out.incni  = 1'b1;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobe-width counter, CPU_END entry flag and byte pointer
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_stb_cnt  <= '0;
      r_end_seen <= 1'b0;
      r_bo       <= '0;
    end else begin
      if (((r_state == S_CPU_STB) || (r_state == S_DMA_STB)) && !w_stb_last)
        r_stb_cnt <= r_stb_cnt + 1'b1;
      else
        r_stb_cnt <= '0;
      r_end_seen <= (r_state == S_CPU_END);
      if (r_state == S_DMA_END)
        r_bo <= r_bo + 1'b1;
      else if ((r_state == S_FLUSH) && !FIFOFULL)
        r_bo <= '0;
      else if ((r_state == S_IDLE) && CLR_BO)
        r_bo <= '0;
    end
  end

  // Output register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_out <= '0;
    else         r_out <= w_out;
  end

  assign SCSI_CS   = r_out.scsi_cs;
  assign RE        = r_out.re;
  assign WE        = r_out.we;
  assign DACK      = r_out.dack;
  assign SET_DSACK = r_out.set_dsack;
  assign CPU2S     = r_out.cpu2s;
  assign S2CPU     = r_out.s2cpu;
  assign F2S       = r_out.f2s;
  assign S2F       = r_out.s2f;
  assign RDFIFO    = r_out.rdfifo;
  assign RIFIFO    = r_out.rififo;
  assign INCBO     = r_out.incbo;
  assign INCNI     = r_out.incni;
  assign INCNO     = r_out.incno;
  assign BO        = r_bo;
  assign TC_DONE   = w_tc_done;

endmodule

// File: doc/scsi_dma_seq.md
# scsi_dma_seq

Parametrised SCSI bus sequencer for the DMAC, successor to the fixed 32-bit SCSI state-machine core. It has these responsibilities:
- Arbitrate between CPU register accesses and DMA byte transfers to the SCSI controller IC.
- Generate CS/RE/WE/DACK strobes of programmable width.
- Own the FIFO byte pointer internally for any power-of-two word width.
- Flush partial words when DMA stops.
- Optionally stop at a terminal byte count.

## Interface
Parameters:
- BYTES_PER_WORD, 4, bytes per FIFO word; power of two, 2..8
- STROBE_CYC, 2, cycles each CS/DACK strobe is held; 1..15
- CNT_W, 24, terminal-count width

Ports:
- CLK  in  1  clock; single clock domain
- nRESET  in  1  reset; asynchronous, active-low
- CCPUREQ  in  1  CPU requests SCSI register access
- RW  in  1  CPU direction; 1 = read
- CDREQ_  in  1  SCSI IC data request, active-low; already synchronised to CLK
- DMAENA  in  1  DMA enabled
- DMADIR  in  1  1 = FIFO→SCSI (F2S), 0 = SCSI→FIFO (S2F)
- FIFOEMPTY, FIFOFULL  in  1  FIFO flags
- CLR_BO  in  1  clears byte pointer; honoured in IDLE only
- TC_LOAD  in  1  load TC_VAL into byte counter
- TC_VAL  in  CNT_W  byte count
- SCSI_CS, RE, WE, DACK  out  1  SCSI IC strobes
- SET_DSACK  out  1  one-cycle pulse ending a CPU access
- CPU2S, S2CPU, F2S, S2F  out  1  datapath steering
- RDFIFO, RIFIFO  out  1  one-cycle FIFO read / write-word pulses
- INCBO, INCNI, INCNO  out  1  one-cycle pointer-increment pulses
- BO  out  $clog2(BYTES_PER_WORD)  current byte lane
- TC_DONE  out  1  byte count exhausted

## Operation
States:
- IDLE:
  - CCPUREQ → CPU_STB. CPU wins any tie with DMA.
  - Otherwise, with DMAENA & !CDREQ_ & !TC_DONE & ready → DMA_STB.
  - Ready means: F2S with (BO≠0 | !FIFOEMPTY), or S2F with !FIFOFULL.
  - Otherwise, if FLUSH_PEND → FLUSH.
- CPU_STB:
  - SCSI_CS=1; RE=RW; WE=!RW; CPU2S=!RW; S2CPU=RW.
  - Held STROBE_CYC cycles, then → CPU_END.
- CPU_END:
  - SET_DSACK pulse; strobes low.
  - CCPUREQ must drop before re-arbitration; stay in CPU_END while it is high.
  - → IDLE.
- DMA_STB:
  - DACK=1; WE=DMADIR; RE=!DMADIR; F2S/S2F per DMADIR.
  - F2S with BO==0: RDFIFO pulses in the first strobe cycle.
  - Held STROBE_CYC cycles, then → DMA_END.
- DMA_END:
  - Strobes low; INCBO pulse; BO increments, wrapping at BYTES_PER_WORD.
  - If BO was BYTES_PER_WORD-1: F2S pulses INCNO; S2F pulses RIFIFO and INCNI.
  - → IDLE.
- FLUSH:
  - Entered only when S2F, !DMAENA and BO≠0.
  - Pulses RIFIFO and INCNI and clears BO; partial word written. Requires !FIFOFULL, else waits in FLUSH.
  - → IDLE.
- FLUSH_PEND is combinational: !DMAENA & !DMADIR & BO≠0.
- DMAENA falling mid-strobe: the current byte completes normally, then FLUSH applies.
- DMADIR change while BO≠0 is illegal. The block takes no action.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge n → strobe high from edge n+1 for exactly STROBE_CYC cycles.
- END pulse lasts 1 cycle.
- One byte = STROBE_CYC+2 cycles, IDLE included. Minimum CPU access = STROBE_CYC+2.
- Reset (any time, including mid-strobe):
  - state IDLE
  - all strobes and pulses 0
  - BO=0
  - counter=0
  - TC_DONE=0
  - no FIFO pulse is issued for an aborted byte.

## Configuration
- SCSI_DMA_SEQ_TC_EN defined:
  - A CNT_W-bit down-counter is loaded by TC_LOAD (only in IDLE).
  - It decrements in each DMA_END.
  - TC_DONE=1 when the loaded count reaches 0, which blocks further DMA.
  - Loading 0 sets TC_DONE immediately.
- Undefined:
  - Counter absent; TC_LOAD and TC_VAL ignored; TC_DONE tied 0.
  - Ports are retained in both builds.

## Structure
- Package scsi_dma_pkg holds:
  - the state enum with one-hot encoding
  - the BO width function
  - the STROBE_CYC range limits
- Sub-module scsi_dma_tc: the terminal counter. It has load, decrement and done, and is instantiated only under SCSI_DMA_SEQ_TC_EN.
- Strobe-width counter and byte pointer are inline.

## Test plan
- CPU read, STROBE_CYC=2: CCPUREQ=1, RW=1 → SCSI_CS and RE high 2 cycles, S2CPU=1, then SET_DSACK 1-cycle pulse; WE never high.
- CCPUREQ and !CDREQ_ asserted in the same cycle → CPU access first; DACK follows only after CPU_END completes.
- F2S, BYTES_PER_WORD=4, FIFO non-empty, 8 bytes → RDFIFO pulses at bytes 0 and 4; INCNO after bytes 3 and 7; BO sequence 0,1,2,3,0,…
- S2F, 6 bytes, then DMAENA=0 → RIFIFO/INCNI after byte 3; FLUSH RIFIFO after byte 5; BO=0.
- TC_EN build, TC_VAL=3, CDREQ_ held low → exactly 3 DACK strobes, then TC_DONE=1 and no further DACK.
- nRESET pulsed during the second DMA_STB cycle → all outputs 0 next cycle; BO=0; no INCBO.
